// File: rtl/mem_param_ctrl.sv
// mem_param_ctrl: single-port synchronous memory with byte-enable writes,
// a 1- or 2-cycle registered read path and a clear sequencer that zeroes
// every location after reset or on a clr request.
module mem_param_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  clr,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [BE_W-1:0]   mem_be_d;
  logic              rd_acc_d;

  logic [DATA_W-1:0] rdata_p1_q, rdata_p1_d;
  logic              vld_p1_q, vld_p1_d;

  // Sequencer: sweep zeroes during CLEAR, user accesses only in READY
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    err_d       = 1'b0;
    mem_we_d    = 1'b0;
    mem_waddr_d = addr;
    mem_wdata_d = wdata;
    mem_be_d    = be;
    rd_acc_d    = 1'b0;
    if (state_q == ST_CLEAR) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = ptr_q;
      mem_wdata_d = '0;
      mem_be_d    = '1;
      err_d       = rd_en | wr_en;
      if (ptr_q == LAST_ADDR) begin
        state_d = ST_READY;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end else begin
      mem_we_d = wr_en;
      rd_acc_d = rd_en;
      // The access on the clr edge is still honoured; the sweep starts next edge
      if (clr) begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    end
  end

  // Control state and error pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  // Memory array with per-byte write gating; not reset, the sweep zeroes it
  always_ff @(posedge clk) begin
    if (reset && mem_we_d) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_be_d[i]) begin
          mem_q[mem_waddr_d][8*i +: 8] <= mem_wdata_d[8*i +: 8];
        end
      end
    end
  end

  // Read stage 1: array is sampled before this edge's write (read-first)
  always_comb begin
    vld_p1_d   = rd_acc_d;
    rdata_p1_d = rd_acc_d ? mem_q[addr] : rdata_p1_q;
  end

  // ---- stage p1 boundary ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_p1_q <= '0;
      vld_p1_q   <= 1'b0;
    end else begin
      rdata_p1_q <= rdata_p1_d;
      vld_p1_q   <= vld_p1_d;
    end
  end

  if (RD_LAT >= 2) begin : g_lat2
    logic [DATA_W-1:0] rdata_p2_q, rdata_p2_d;
    logic              vld_p2_q, vld_p2_d;

    // Read stage 2: extra output register, holds data between valid pulses
    always_comb begin
      vld_p2_d   = vld_p1_q;
      rdata_p2_d = vld_p1_q ? rdata_p1_q : rdata_p2_q;
    end

    // ---- stage p2 boundary ----
    always_ff @(posedge clk) begin
      if (!reset) begin
        rdata_p2_q <= '0;
        vld_p2_q   <= 1'b0;
      end else begin
        rdata_p2_q <= rdata_p2_d;
        vld_p2_q   <= vld_p2_d;
      end
    end

    assign rdata    = rdata_p2_q;
    assign rd_valid = vld_p2_q;
  end else begin : g_lat1
    assign rdata    = rdata_p1_q;
    assign rd_valid = vld_p1_q;
  end

  assign busy = (state_q == ST_CLEAR);
  assign err  = err_q;

endmodule

// File: doc/mem_param_ctrl.md
# mem_param_ctrl

Parametrised single-port synchronous memory with byte-enable writes, a configurable read latency and a hardware clear sequencer that zeroes every location after reset or on request. It generalises the existing 16×16 memory DUT behind the `mem_if` bench. The bench drives the DUT through the same rd/wr/addr/wdata/rdata signal set, extended with byte enables, read-valid, clear and status signals.

## Interface
- `DATA_W`, default 16: data width in bits; must be a multiple of 8.
- `ADDR_W`, default 4: address width; DEPTH = 2**ADDR_W.
- `RD_LAT`, default 1: read latency in cycles; legal values are 1 and 2.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `rd_en`, input, 1: read request; sampled on the rising edge.
- `wr_en`, input, 1: write request; sampled on the rising edge.
- `addr`, input, ADDR_W: shared read/write address.
- `wdata`, input, DATA_W: write data.
- `be`, input, DATA_W/8: byte enables; bit i gates `wdata[8i+7:8i]`.
- `clr`, input, 1: request a full memory clear sweep.
- `rdata`, output, DATA_W: read data; holds its last value when `rd_valid` is 0.
- `rd_valid`, output, 1: `rdata` is valid this cycle.
- `busy`, output, 1: clear sweep in progress; accesses are ignored.
- `err`, output, 1: one-cycle pulse when `rd_en` or `wr_en` is sampled while `busy` is 1.

## Operation
- FSM states are CLEAR and READY.
- **Reset** (`reset`=0 at an edge):
  - state ← CLEAR, clear pointer ← 0.
  - `busy`=1; `rdata`=0; `rd_valid`=0; `err`=0.
  - Read pipeline flushed.
  - Memory array contents are not reset directly; the sweep zeroes them.
- **CLEAR**:
  - Each cycle writes 0 to location `ptr`, then `ptr` increments.
  - At `ptr`=DEPTH-1 the FSM writes that location and moves to READY; `busy` falls at the same edge.
  - `clr` is ignored in this state.
  - Any `rd_en` or `wr_en` is dropped, and `err` pulses for one cycle.
- **READY**:
  - Write: when `wr_en`=1, for each byte with `be[i]`=1, mem[addr] byte i ← wdata byte i. Other bytes are unchanged. `be`=0 is a legal no-op.
  - Read: when `rd_en`=1, mem[addr] is read with read-first semantics. With `rd_en`=1 and `wr_en`=1 on the same address, `rdata` returns the pre-write contents. Different addresses are impossible on a single port.
  - `clr`=1:
    - At that edge, any `wr_en` and `rd_en` are also honoured.
    - FSM → CLEAR, `ptr` ← 0.
    - Reads already in the pipeline still complete with `rd_valid`.
- **Reset mid-sweep**: the sweep restarts from address 0, and `busy` stays 1.
- `err` never asserts in READY.

## Timing
- Read latency:
  - `rd_en` sampled at edge N gives `rdata`/`rd_valid` registered at edge N+RD_LAT-1 when RD_LAT=1. Data is visible in the cycle after the request.
  - For RD_LAT=2, data is visible two cycles after the request, with an extra output register.
- `rd_valid` is a one-cycle pulse per accepted read. Back-to-back reads give back-to-back valid cycles at full throughput.
- Write latency: data written at edge N is readable by a read sampled at edge N+1.
- Clear duration: `busy` is 1 for exactly DEPTH cycles after the first edge with `reset`=1, or after the edge that samples `clr` in READY.
- `err` is registered: it asserts in the cycle after the offending edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Reset sweep** (DATA_W=16, ADDR_W=4): hold `reset`=0 for 3 cycles, then release.
  - `busy`=1 for exactly 16 cycles, then 0.
  - Reading addresses 0–15 returns 0x0000 each time, with `rd_valid` 1 cycle after each request.
- **Basic write/read**: write 0xA5A5, `be`=2'b11, to addr 3, then read addr 3.
  - `rdata`=0xA5A5 with a single `rd_valid` pulse.
  - With RD_LAT=2 the response arrives one cycle later.
- **Byte enables**: write 0x1234 (`be`=11) to addr 5, then write 0xABCD (`be`=01), then read addr 5.
  - Returns 0x12CD.
- **Read-first collision**: addr 7 holds 0x1111. Assert `rd_en`+`wr_en` on addr 7 with `wdata`=0x2222.
  - That read returns 0x1111.
  - The next read returns 0x2222.
- **Access while busy**: issue `wr_en` to addr 2 with 0xFFFF during the reset sweep.
  - `err` pulses once.
  - After `busy` falls, addr 2 reads 0x0000.
- **Clear and reset mid-operation**:
  - Fill all locations with 0x5A5A. Issue `rd_en` addr 1 and `clr` on the same edge: the read returns 0x5A5A, then `busy` is 1 for 16 cycles and every location reads 0.
  - Assert `reset` at sweep cycle 8: the sweep restarts, and `busy` lasts 16 more cycles after release.
